// File: rtl/data_mem_bridge_if.sv
// Split-transaction data bus between the CPU data-port bridge (master)
// and the SRAM-like memory (slave).
interface data_mem_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Converts the CPU's single-cycle load/store port into one addr_ok/data_ok bus
// transaction per access, stalling the pipeline and bounding the wait with a watchdog.
//
// state | meaning
// IDLE  | no access; capture CPU request when cpu_req is high
// REQ   | data_req asserted, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok (watchdog running)
// DONE  | access finished for one cycle; pipeline released
module data_mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic [3:0]         cpu_wen,
  input  logic [1:0]         cpu_size,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_stall,
  output logic               cpu_err,
  data_mem_bridge_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        cap, rd_load, tmo, cnt_clr, cnt_inc;

  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  // Irregular strobe patterns fall back to a word-sized access with the strobe kept as-is.
  function automatic logic [1:0] wsize(input logic [3:0] wen);
    logic [1:0] s;
    s = 2'd2;
    case (wen)
      4'b1111:                            s = 2'd2;
      4'b0011, 4'b1100:                   s = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: s = 2'd0;
      default:                            s = 2'd2;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    rd_load   = 1'b0;
    tmo       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          cap       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            rd_load   = ~wr_q;
            state_nxt = DONE;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.data_data_ok) begin
          rd_load   = ~wr_q;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      cpu_rdata <= 32'd0;
      cpu_err   <= 1'b0;
      cnt       <= 16'd0;
    end else begin
      if (cap) begin
        wr_q    <= |cpu_wen;
        size_q  <= (|cpu_wen) ? wsize(cpu_wen) : cpu_size;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wen;
      end
      if (rd_load) cpu_rdata <= bus.data_rdata;
      if (tmo) begin
        cpu_rdata <= 32'd0;
        cpu_err   <= 1'b1;
      end
      if (cnt_clr)      cnt <= 16'd0;
      else if (cnt_inc) cnt <= cnt + 16'd1;
    end
  end

  assign bus.data_req   = (state == REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign bus.data_wstrb = wstrb_q;

  assign cpu_stall = ((state == IDLE) && cpu_req) || (state == REQ) || (state == WAIT);

endmodule
